dcache_plru_buffer: RTL



---
 rtl/dcache_pkg.sv | 12 +
 rtl/dcache_plru_touch.sv | 27 ++
 rtl/dcache_plru_buffer.sv | 113 +++++++++++
 3 files changed

// File: rtl/dcache_pkg.sv
// Shared dcache definitions: geometry, way index and PLRU vector types.
package dcache_pkg;

  localparam int DCACHE_SETS    = 64;
  localparam int DCACHE_INDEX_W = 6;
  localparam int DCACHE_WAYS    = 8;
  localparam int DCACHE_PLRU_W  = 7;

  typedef logic [$clog2(DCACHE_WAYS)-1:0] way_t;
  typedef logic [DCACHE_PLRU_W-1:0]       plru_t;

endpackage

// File: rtl/dcache_plru_touch.sv
// Combinational tree-PLRU touch: steers the three path bits of the
// touched way so that they point away from it; off-path bits pass through.
// bit0 = root, bit1/bit2 = mid nodes, bit3..bit6 = leaves; 0 = left is LRU.
module dcache_plru_touch
  import dcache_pkg::*;
(
  input  plru_t plru_i,
  input  way_t  way_i,
  output plru_t plru_o
);

  // Rewrite root, mid node and leaf on the path to way_i.
  always_comb begin
    plru_o    = plru_i;
    plru_o[0] = ~way_i[2];
    if (!way_i[2]) begin
      plru_o[1] = ~way_i[1];
      if (!way_i[1]) plru_o[3] = ~way_i[0];
      else           plru_o[4] = ~way_i[0];
    end else begin
      plru_o[2] = ~way_i[1];
      if (!way_i[1]) plru_o[5] = ~way_i[0];
      else           plru_o[6] = ~way_i[0];
    end
  end

endmodule

// File: rtl/dcache_plru_buffer.sv
// Per-set tree-PLRU state store for the 8-way dcache. Fill and hit touches
// are chained (fill first, hit on top) so a same-set hit is most recent.
// Reads take one cycle and see all updates of their own cycle.
// Optional macro DCACHE_PLRU_FLUSH_EN adds i_flush, which clears every set
// in one cycle and overrides same-cycle touches.
module dcache_plru_buffer
  import dcache_pkg::*;
#(
  parameter int SETS    = DCACHE_SETS,
  parameter int INDEX_W = DCACHE_INDEX_W,
  parameter int PLRU_W  = DCACHE_PLRU_W
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_rd_valid,
  input  logic [INDEX_W-1:0] i_rd_index,
  input  logic               i_hit_valid,
  input  logic [INDEX_W-1:0] i_hit_index,
  input  logic [2:0]         i_hit_way,
  input  logic               i_fill_valid,
  input  logic [INDEX_W-1:0] i_fill_index,
  input  logic [2:0]         i_fill_way,
`ifdef DCACHE_PLRU_FLUSH_EN
  input  logic               i_flush,
`endif
  output logic               o_rd_valid,
  output logic [INDEX_W-1:0] o_rd_index,
  output logic [PLRU_W-1:0]  o_plru_out_7
);

  logic [PLRU_W-1:0]  state_q [SETS];
  logic [PLRU_W-1:0]  state_d [SETS];
  plru_t              fill_old, fill_new, hit_old, hit_new;
  logic               flush;
  logic               rd_valid_q;
  logic [INDEX_W-1:0] rd_index_q, rd_index_d;
  logic [PLRU_W-1:0]  plru_q, plru_d;

`ifdef DCACHE_PLRU_FLUSH_EN
  assign flush = i_flush;
`else
  assign flush = 1'b0;
`endif

  // Hit starts from the fill result when both touch the same set.
  always_comb begin
    fill_old = state_q[i_fill_index];
    hit_old  = state_q[i_hit_index];
    if (i_fill_valid && (i_fill_index == i_hit_index)) hit_old = fill_new;
  end

  dcache_plru_touch u_touch_fill (
    .plru_i (fill_old),
    .way_i  (i_fill_way),
    .plru_o (fill_new)
  );

  dcache_plru_touch u_touch_hit (
    .plru_i (hit_old),
    .way_i  (i_hit_way),
    .plru_o (hit_new)
  );

  // Next state: flush wins; otherwise fill, then hit (which already
  // contains the fill when the sets collide).
  always_comb begin
    state_d = state_q;
    if (flush) begin
      for (int i = 0; i < SETS; i++) state_d[i] = '0;
    end else begin
      if (i_fill_valid) state_d[i_fill_index] = fill_new;
      if (i_hit_valid)  state_d[i_hit_index]  = hit_new;
    end
  end

  // Read path: write-first by reading the post-update state; data and
  // index hold while no read is issued.
  always_comb begin
    rd_index_d = rd_index_q;
    plru_d     = plru_q;
    if (i_rd_valid) begin
      rd_index_d = i_rd_index;
      plru_d     = state_d[i_rd_index];
    end
  end

  // PLRU state array, cleared by reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < SETS; i++) state_q[i] <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  // Read response registers; reset drops any in-flight read.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rd_valid_q <= 1'b0;
      rd_index_q <= '0;
      plru_q     <= '0;
    end else begin
      rd_valid_q <= i_rd_valid;
      rd_index_q <= rd_index_d;
      plru_q     <= plru_d;
    end
  end

  assign o_rd_valid   = rd_valid_q;
  assign o_rd_index   = rd_index_q;
  assign o_plru_out_7 = plru_q;

endmodule
